ser_tx: RTL and testbench

SER_TX -- requirements
Module: ser_tx

---
 rtl/ser_pkg.sv | 12 +
 rtl/baud_tick_gen.sv | 16 +
 rtl/ser_tx.sv | 83 ++++++++
 tb/tb_ser_tx.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and default parameters for ser_tx.
// Defining SER_TX_PARITY_EN adds the PARITY state.
package ser_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DIV_DEF = 4;
    localparam logic IDLE_LEVEL = 1'b1;
`ifdef SER_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period divider; tick is high in the last clock of each DIV-clock bit.
module baud_tick_gen
    import ser_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    logic [15:0] cnt;
    assign tick = cnt == 16'(DIV - 1);
    always_ff @(posedge clk)
        cnt <= (rst || restart || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/ser_tx.sv
// ser_tx: start/data(LSB first)/stop serializer with a ready/valid word input.
// Defining SER_TX_PARITY_EN inserts an even-parity bit after the data bits.
module ser_tx
    import ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV = DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int BW = $clog2(DATA_W);
    state_t state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [BW-1:0] bit_cnt;
    logic tick, accept, last, line_nxt;
`ifdef SER_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk)
        par <= rst ? 1'b0 : accept ? ^tx_data : par;
`endif
    assign accept = tx_valid && tx_ready;
    assign last = bit_cnt == BW'(DATA_W - 1);
    // The divider is held at zero while idle so each frame starts on a clean bit boundary.
    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk(clk),
        .rst(rst),
        .restart(state == IDLE),
        .tick(tick)
    );
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = tx_valid ? START : IDLE;
            START:  state_nxt = tick ? DATA : START;
`ifdef SER_TX_PARITY_EN
            DATA:   state_nxt = (tick && last) ? PARITY : DATA;
            PARITY: state_nxt = tick ? STOP : PARITY;
`else
            DATA:   state_nxt = (tick && last) ? STOP : DATA;
`endif
            STOP:   state_nxt = tick ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        tx_ready = !rst && state == IDLE;
        tx_busy = !rst && state != IDLE;
        tx_done = !rst && state == STOP && tick;
    end
    // tx_out is registered, so the line level is derived from the state being entered.
    always_comb begin
        shift_nxt = accept ? tx_data : (state == DATA && tick) ? shift >> 1 : shift;
        line_nxt = IDLE_LEVEL;
        if (state_nxt == START)
            line_nxt = 1'b0;
        else if (state_nxt == DATA)
            line_nxt = shift_nxt[0];
`ifdef SER_TX_PARITY_EN
        else if (state_nxt == PARITY)
            line_nxt = par;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            bit_cnt <= '0;
            tx_out <= IDLE_LEVEL;
        end else begin
            shift <= shift_nxt;
            tx_out <= line_nxt;
            bit_cnt <= (state == DATA && tick) ? (last ? '0 : bit_cnt + 1'b1) : bit_cnt;
        end
    end
endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: randomized and directed frames checked cycle by cycle against a bit-list model.
module tb_ser_tx;
`ifdef SER_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tx_data = '0, tx_data2 = '0;
    logic tx_valid = 1'b0, tx_valid2 = 1'b0;
    logic tx_ready, tx_out, tx_busy, tx_done;
    logic ready2, out2, busy2, done2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ser_tx #(.DATA_W(8), .DIV(4)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    ser_tx #(.DATA_W(8), .DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(ready2), .tx_out(out2), .tx_busy(busy2), .tx_done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected line per clock = list of frame bits, each stretched over div clocks.
    task automatic send(input bit sel, input logic [7:0] d, input bit keep);
        int div, len;
        logic exp_bits[$];
        div = sel ? 2 : 4;
        exp_bits = {1'b0};
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (PAR == 1) exp_bits.push_back(^d);
        exp_bits.push_back(1'b1);
        len = exp_bits.size() * div;
        check("ready_pre", sel ? ready2 : tx_ready, 1);
        if (sel) begin
            tx_data2 = d;
            tx_valid2 = 1'b1;
        end else begin
            tx_data = d;
            tx_valid = 1'b1;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check("line", sel ? out2 : tx_out, exp_bits[(k - 1) / div]);
            check("done", sel ? done2 : tx_done, k == len);
            check("busy", sel ? busy2 : tx_busy, 1);
            check("ready_in_frame", sel ? ready2 : tx_ready, 0);
            if (k == 1) begin
                if (sel) begin
                    tx_data2 = ~d;
                    tx_valid2 = keep;
                end else begin
                    tx_data = ~d;
                    tx_valid = keep;
                end
            end
        end
        @(negedge clk);
        check("idle_line", sel ? out2 : tx_out, 1);
        check("idle_busy", sel ? busy2 : tx_busy, 0);
        check("idle_done", sel ? done2 : tx_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_line", tx_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_line2", out2, 1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);
        send(0, 8'hA5, 0);
        send(0, 8'h07, 0);
        send(0, 8'h00, 1);
        send(0, 8'hFF, 0);
        send(0, 8'h3C, 0);
        for (int n = 0; n < 12; n++)
            send(0, 8'($urandom), (n < 11) ? 1'($urandom) : 1'b0);
        // Abort a frame during the third data bit.
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_line", tx_out, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", tx_ready, 0);
        check("abort_done", tx_done, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", tx_done, 0);
            check("abort_hold_line", tx_out, 1);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", tx_ready, 1);
        check("abort_busy_after", tx_busy, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_done", tx_done, 0);
        end
        send(0, 8'hC3, 0);
        send(1, 8'h01, 0);
        send(1, 8'($urandom), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
